// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered front-end that paces one-cycle load pulses
// into a downstream uart so each stored word goes out as a full frame.
module uart_tx_feeder #(
    parameter int DEPTH      = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DEPTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          uart_enable,
    output logic [DEPTH-1:0]              uart_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    // state | meaning
    // IDLE  | FIFO empty, waiting for a word
    // LOAD  | word popped into uart_data; enable pulse follows
    // SHIFT | downstream serialising DEPTH data bits
    // GAP   | STOP_BITS idle-high cycles before the next load

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (DEPTH > STOP_BITS) ? DEPTH : STOP_BITS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [DEPTH-1:0] mem [FIFO_DEPTH];
    logic             push, pop, cnt_zero, fifo_nonempty;

    assign in_ready      = (count != (AW+1)'(FIFO_DEPTH));
    assign push          = in_valid && in_ready;
    assign cnt_zero      = (bit_cnt == '0);
    assign fifo_nonempty = (count != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fifo_nonempty) state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (cnt_zero) state_nxt = GAP;
            GAP:   if (cnt_zero) state_nxt = fifo_nonempty ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop decode: head leaves the FIFO on the edge that enters LOAD
    always_comb begin
        pop = 1'b0;
        if (fifo_nonempty && (state == IDLE || (state == GAP && cnt_zero)))
            pop = 1'b1;
    end

    // Down-counter timing the SHIFT and GAP phases
    always_ff @(posedge clk) begin
        if (rst)
            bit_cnt <= '0;
        else if (state == LOAD)
            bit_cnt <= CW'(DEPTH - 1);
        else if (state == SHIFT && cnt_zero)
            bit_cnt <= CW'(STOP_BITS - 1);
        else if (!cnt_zero)
            bit_cnt <= bit_cnt - 1'b1;
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy is cleared
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= in_data;
    end

    // Registered outputs; enable trails LOAD by one cycle so uart_data is settled
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_enable <= 1'b0;
            uart_data   <= '0;
            busy        <= 1'b0;
        end else begin
            uart_enable <= (state == LOAD);
            busy        <= (state != IDLE);
            if (pop) uart_data <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: default instance plus a STOP_BITS=2 instance.
module tb_uart_tx_feeder;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid2;
    logic [4:0] in_data, in_data2;
    logic       in_ready, in_ready2;
    logic       uart_enable, uart_enable2;
    logic [4:0] uart_data, uart_data2;
    logic       busy, busy2;
    logic [3:0] count, count2;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [4:0] log_data[$];
    int         log_cyc[$];
    logic [4:0] log_data2[$];
    int         log_cyc2[$];

    uart_tx_feeder #(.DEPTH(5), .FIFO_DEPTH(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .uart_enable(uart_enable), .uart_data(uart_data),
        .busy(busy), .count(count)
    );

    uart_tx_feeder #(.DEPTH(5), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .uart_enable(uart_enable2), .uart_data(uart_data2),
        .busy(busy2), .count(count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every load pulse with its cycle number and word
    always @(negedge clk) begin
        if (uart_enable) begin
            log_data.push_back(uart_data);
            log_cyc.push_back(cyc);
        end
        if (uart_enable2) begin
            log_data2.push_back(uart_data2);
            log_cyc2.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        int n;
        int d;
        logic [4:0] exp_seq [11];

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0;
        in_valid2 = 1'b0; in_data2 = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_enable", 32'(uart_enable), 0);
        chk("rst_data",   32'(uart_data),   0);
        chk("rst_busy",   32'(busy),        0);
        chk("rst_count",  32'(count),       0);
        chk("rst_ready",  32'(in_ready),    1);

        // Single word: accept E0, pop E1, pulse E2
        in_valid = 1'b1; in_data = 5'b10110;
        tick();
        in_valid = 1'b0;
        chk("single_count_e0", 32'(count), 1);
        chk("single_busy_e0",  32'(busy),  0);
        tick();
        chk("single_count_e1", 32'(count),       0);
        chk("single_en_e1",    32'(uart_enable), 0);
        tick();
        chk("single_en_e2",   32'(uart_enable), 1);
        chk("single_data_e2", 32'(uart_data),   32'h16);
        chk("single_busy_e2", 32'(busy),        1);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        chk("single_busy_len", 32'(n), 7);
        chk("single_pulses", 32'(log_data.size()), 1);

        // Burst fill until full, then stall 0x1F while full
        log_data.delete(); log_cyc.delete();
        d = 1;
        in_valid = 1'b1;
        n = 0;
        while (in_ready && n < 50) begin
            in_data = 5'(d);
            tick();
            d++;
            n++;
        end
        chk("burst_accepted", 32'(d - 1), 10);
        chk("burst_full_count", 32'(count), 8);
        chk("burst_full_ready", 32'(in_ready), 0);
        in_data = 5'h1F;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk("stall_cycles", 32'(n), 6);
        chk("stall_count_after_pop", 32'(count), 7);
        tick();
        in_valid = 1'b0;
        chk("stall_count_after_push", 32'(count), 8);
        n = 0;
        while (!(busy == 1'b0 && count == 0) && n < 200) begin
            tick();
            n++;
        end
        chk("burst_drain_bound", 32'(n < 200), 1);
        for (int i = 0; i < 10; i++) exp_seq[i] = 5'(i + 1);
        exp_seq[10] = 5'h1F;
        chk("burst_pulses", 32'(log_data.size()), 11);
        for (int i = 0; i < 11 && i < log_data.size(); i++)
            chk($sformatf("burst_data_%0d", i), 32'(log_data[i]), 32'(exp_seq[i]));
        for (int i = 1; i < 11 && i < log_cyc.size(); i++)
            chk($sformatf("burst_gap_%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 7);

        // Reset mid-frame with three words queued
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 5'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count_before", 32'(count), 3);
        chk("mid_busy_before",  32'(busy),  1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count",  32'(count),       0);
        chk("mid_rst_busy",   32'(busy),        0);
        chk("mid_rst_enable", 32'(uart_enable), 0);
        chk("mid_rst_ready",  32'(in_ready),    1);
        log_data.delete(); log_cyc.delete();
        repeat (30) tick();
        chk("mid_no_pulses", 32'(log_data.size()), 0);
        in_valid = 1'b1; in_data = 5'h0A;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (log_data.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_new_pulse", 32'(log_data.size()), 1);
        if (log_data.size() > 0) chk("mid_new_data", 32'(log_data[0]), 32'h0A);

        // STOP_BITS=2: pulses 8 cycles apart
        log_data2.delete(); log_cyc2.delete();
        in_valid2 = 1'b1; in_data2 = 5'h03;
        tick();
        in_data2 = 5'h15;
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (log_data2.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        chk("sb2_pulses", 32'(log_data2.size()), 2);
        if (log_data2.size() >= 2) begin
            chk("sb2_data0", 32'(log_data2[0]), 32'h03);
            chk("sb2_data1", 32'(log_data2[1]), 32'h15);
            chk("sb2_gap",   32'(log_cyc2[1] - log_cyc2[0]), 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
